// File: rtl/park_pkg.sv
// Shared definitions for the parking-lot entry controller: default sizes,
// FSM state encoding and the LFSR seed/tap definition.
package park_pkg;

    localparam int SPOT_W    = 3;
    localparam int NUM_SPOTS = 1 << SPOT_W;

    // Non-zero reset value of the pattern LFSR.
    localparam logic [SPOT_W-1:0] LFSR_SEED = 3'b101;

    // Feedback taps: next = {q[1:0], q[2]^q[1]} (maximal length, period 7).
    localparam logic [SPOT_W-1:0] LFSR_TAPS = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        ISSUE,
        GATE,
        WAIT_REL
    } park_state_t;

    // One LFSR step, usable by RTL and by any reference model.
    function automatic logic [SPOT_W-1:0] lfsr_next(input logic [SPOT_W-1:0] q);
        return {q[SPOT_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/park_lfsr.sv
// Fibonacci LFSR that steps only when adv is high; holds otherwise.
module park_lfsr #(
    parameter int               W    = park_pkg::SPOT_W,
    parameter logic [W-1:0]     SEED = park_pkg::LFSR_SEED,
    parameter logic [W-1:0]     TAPS = park_pkg::LFSR_TAPS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    output logic [W-1:0] q
);

    // Shift left, feeding back the parity of the tapped bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (adv) begin
            q <= {q[W-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/park_entry_alloc.sv
// Entry-side parking controller: allocates the lowest free spot, issues
// token = spot ^ pattern, runs the entry gate and frees spots on exit.
// Optional statistics counters are built when PARK_STATS_EN is defined.
module park_entry_alloc #(
    parameter int                    NUM_SPOTS   = park_pkg::NUM_SPOTS,
    parameter int                    SPOT_W      = park_pkg::SPOT_W,
    parameter logic [SPOT_W-1:0]     LFSR_SEED   = park_pkg::LFSR_SEED,
    parameter int                    GATE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enter_req,
    output logic                  enter_ack,
    output logic [SPOT_W-1:0]     token,
    output logic [SPOT_W-1:0]     pattern,
    output logic [SPOT_W-1:0]     spot,
    output logic                  gate_open,
    output logic                  full,
    input  logic                  exit_valid,
    input  logic [SPOT_W-1:0]     exit_park_number,
    output logic                  exit_err,
    output logic [NUM_SPOTS-1:0]  occ_map
`ifdef PARK_STATS_EN
    ,
    output logic [7:0]            entry_count,
    output logic [7:0]            reject_count
`endif
);

    import park_pkg::*;

    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    park_state_t           state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [SPOT_W-1:0]     lfsr_q;
    logic [SPOT_W-1:0]     alloc_spot_next;
    logic [NUM_SPOTS-1:0]  occ_next;
    logic                  alloc_en;

    // Lowest-numbered zero bit of the occupancy map.
    function automatic logic [SPOT_W-1:0] first_free(input logic [NUM_SPOTS-1:0] m);
        logic [SPOT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!m[i]) begin
                idx = SPOT_W'(i);
            end
        end
        return idx;
    endfunction

    assign full            = &occ_map;
    assign alloc_en        = (state_reg == ALLOC);
    assign alloc_spot_next = first_free(occ_map);

    park_lfsr #(
        .W    (SPOT_W),
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (alloc_en),
        .q     (lfsr_q)
    );

    // Per-spot next occupancy: an exit clears a taken bit, an allocation sets
    // its bit. Allocation uses the map from the start of the cycle, so a spot
    // freed in the same cycle is only eligible from the next one.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPOTS; gi++) begin : g_occ
            assign occ_next[gi] =
                (occ_map[gi] & ~(exit_valid && (exit_park_number == SPOT_W'(gi)))) |
                (alloc_en && (alloc_spot_next == SPOT_W'(gi)));
        end
    endgenerate

    // Occupancy register and exit error pulse, active in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_map  <= '0;
            exit_err <= 1'b0;
        end else begin
            occ_map  <= occ_next;
            exit_err <= exit_valid && !occ_map[exit_park_number];
        end
    end

    // Entry FSM with registered ack, gate and token/pattern/spot outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            token     <= '0;
            pattern   <= '0;
            spot      <= '0;
            enter_ack <= 1'b0;
            gate_open <= 1'b0;
        end else begin
            enter_ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enter_req && !full) begin
                        state_reg <= ALLOC;
                    end
                end
                ALLOC: begin
                    spot      <= alloc_spot_next;
                    pattern   <= lfsr_q;
                    token     <= alloc_spot_next ^ lfsr_q;
                    enter_ack <= 1'b1;
                    state_reg <= ISSUE;
                end
                ISSUE: begin
                    gate_open <= 1'b1;
                    cnt_reg   <= CNT_W'(GATE_CYCLES - 1);
                    state_reg <= GATE;
                end
                GATE: begin
                    if (cnt_reg == '0) begin
                        gate_open <= 1'b0;
                        state_reg <= WAIT_REL;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!enter_req) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef PARK_STATS_EN
    // Saturating counts of issued tokens and of requests blocked at full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_count  <= '0;
            reject_count <= '0;
        end else begin
            if (state_reg == ISSUE && entry_count != 8'hFF) begin
                entry_count <= entry_count + 8'd1;
            end
            if (state_reg == IDLE && enter_req && full && reject_count != 8'hFF) begin
                reject_count <= reject_count + 8'd1;
            end
        end
    end
`endif

endmodule
